conf_buff_n: RTL and testbench



---
 rtl/conf_pkg.sv | 35 +++
 rtl/conf_pulse_gen.sv | 61 ++++++
 rtl/conf_buff_n.sv | 121 ++++++++++++
 tb/tb_conf_buff_n.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conf_pkg.sv
// Shared types and helpers for the N-input confluence buffer.
package conf_pkg;

    localparam int TSTAMP_W = 32;

    typedef struct packed {
        logic valid;
        logic bad;
    } pipe_entry_t;

    typedef enum logic {
        SEP_IDLE,
        SEP_WINDOW
    } sep_state_e;

    typedef enum logic {
        OUT_IDLE,
        OUT_PULSE
    } out_state_e;

    // Bits needed for a down-counter that is loaded with value-1 (at least one bit).
    function automatic int clog2(input int value);
        int w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) cnt = cnt + 5'(v[i]);
        return cnt;
    endfunction

endpackage

// File: rtl/conf_pulse_gen.sv
// Output pulse shaper: stretches each fire to PULSE_W cycles and merges overlapping pulses.
module conf_pulse_gen
    import conf_pkg::*;
#(
    parameter int PULSE_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fire,
    input  logic bad,
    output logic out,
    output logic out_x
);

    localparam int W_W = clog2(PULSE_W);
    localparam logic [W_W-1:0] W_LOAD = W_W'(PULSE_W - 1);

    out_state_e     state, state_n;
    logic [W_W-1:0] wcnt, wcnt_n;
    logic           x_q, x_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OUT_IDLE;
            wcnt  <= '0;
            x_q   <= 1'b0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            x_q   <= x_n;
        end
    end

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        x_n     = x_q;
        if (state == OUT_IDLE) begin
            if (fire) begin
                state_n = OUT_PULSE;
                wcnt_n  = W_LOAD;
                x_n     = bad;
            end
        end else begin
            // A pulse landing on a running one extends it seamlessly but taints it.
            if (fire) begin
                wcnt_n = W_LOAD;
                x_n    = 1'b1;
            end else if (wcnt == '0) begin
                state_n = OUT_IDLE;
                x_n     = 1'b0;
            end else begin
                wcnt_n = wcnt - 1'b1;
            end
        end
    end

    assign out   = (state == OUT_PULSE);
    assign out_x = x_q;

endmodule

// File: rtl/conf_buff_n.sv
// N-input confluence buffer: merges input rising edges into one delayed pulse and flags separation violations.
// Optional event/violation timestamps are enabled by defining CONF_TSTAMP_EN.
module conf_buff_n
    import conf_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int T_SEP   = 10,
    parameter int DELAY   = 2,
    parameter int PULSE_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  in,
    input  logic             cnt_clr,
    output logic             out,
    output logic             out_x,
    output logic             viol,
    output logic [N_IN-1:0]  viol_src,
    output logic [CNT_W-1:0] viol_cnt
`ifdef CONF_TSTAMP_EN
    ,
    output logic [TSTAMP_W-1:0] last_evt_time,
    output logic [TSTAMP_W-1:0] viol_prev_time,
    output logic [TSTAMP_W-1:0] viol_time
`endif
);

    localparam int SEP_W = clog2(T_SEP);
    localparam logic [SEP_W-1:0] SEP_LOAD = SEP_W'(T_SEP - 1);

    logic [N_IN-1:0]  prev;
    logic [N_IN-1:0]  rise;
    logic             evt;
    logic             multi;
    logic             violation;
    sep_state_e       sep_state, sep_state_n;
    logic [SEP_W-1:0] sep_cnt, sep_cnt_n;
    pipe_entry_t      pipe [DELAY];

    assign rise      = in & ~prev;
    assign evt       = |rise;
    assign multi     = popcount(16'(rise)) > 5'd1;
    assign violation = evt & ((sep_state == SEP_WINDOW) | multi);

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        sep_state_n = sep_state;
        sep_cnt_n   = sep_cnt;
        if (evt) begin
            sep_cnt_n   = SEP_LOAD;
            sep_state_n = (SEP_LOAD != '0) ? SEP_WINDOW : SEP_IDLE;
        end else if (sep_state == SEP_WINDOW) begin
            sep_cnt_n = sep_cnt - 1'b1;
            if (sep_cnt == SEP_W'(1)) sep_state_n = SEP_IDLE;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= '1;
            sep_state <= SEP_IDLE;
            sep_cnt   <= '0;
            viol      <= 1'b0;
            viol_src  <= '0;
            viol_cnt  <= '0;
        end else begin
            prev      <= in;
            sep_state <= sep_state_n;
            sep_cnt   <= sep_cnt_n;
            viol      <= violation;
            if (violation) viol_src <= rise;
            if (cnt_clr) viol_cnt <= violation ? CNT_W'(1) : '0;
            else if (violation && !(&viol_cnt)) viol_cnt <= viol_cnt + 1'b1;
        end
    end

    // NOTE: the pipeline is reset on purpose: a reset must cancel pulses already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: evt, bad: violation};
            for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
        end
    end

    conf_pulse_gen #(
        .PULSE_W (PULSE_W)
    ) u_pulse_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .fire  (pipe[DELAY-1].valid),
        .bad   (pipe[DELAY-1].bad),
        .out   (out),
        .out_x (out_x)
    );

`ifdef CONF_TSTAMP_EN
    logic [TSTAMP_W-1:0] tcnt;

    // A window violation refers back to the last event; a pure collision refers to itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt           <= '0;
            last_evt_time  <= '0;
            viol_prev_time <= '0;
            viol_time      <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
            if (evt) last_evt_time <= tcnt;
            if (violation) begin
                viol_time      <= tcnt;
                viol_prev_time <= (sep_state == SEP_WINDOW) ? last_evt_time : tcnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conf_buff_n.sv
// Scoreboard bench for conf_buff_n: stimulus queues expected strobes/pulses, a monitor pops and compares.
module tb_conf_buff_n;

    localparam int N_IN    = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [N_IN-1:0]  in = '0;
    logic             out, out_x, viol;
    logic [N_IN-1:0]  viol_src;
    logic [CNT_W-1:0] viol_cnt;
`ifdef CONF_TSTAMP_EN
    logic [31:0] last_evt_time, viol_prev_time, viol_time;
    int          cyc;
`endif

    typedef struct {
        logic [N_IN-1:0]  src;
        logic [CNT_W-1:0] cnt;
    } viol_rec_t;

    typedef struct {
        int   width;
        logic x_first;
        logic x_last;
    } out_rec_t;

    viol_rec_t viol_q[$];
    out_rec_t  out_q[$];
    int        checks = 0;
    int        errors = 0;
    int        exp_cnt = 0;

    conf_buff_n #(
        .N_IN    (N_IN),
        .T_SEP   (10),
        .DELAY   (2),
        .PULSE_W (2),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .cnt_clr  (cnt_clr),
        .out      (out),
        .out_x    (out_x),
        .viol     (viol),
        .viol_src (viol_src),
        .viol_cnt (viol_cnt)
`ifdef CONF_TSTAMP_EN
        ,
        .last_evt_time  (last_evt_time),
        .viol_prev_time (viol_prev_time),
        .viol_time      (viol_time)
`endif
    );

    always #5 clk = ~clk;

`ifdef CONF_TSTAMP_EN
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_viol(input logic [N_IN-1:0] src, input logic clr);
        if (clr) exp_cnt = 1;
        else if (exp_cnt < CNT_MAX) exp_cnt++;
        viol_q.push_back('{src: src, cnt: CNT_W'(exp_cnt)});
    endtask

    task automatic expect_out(input int width, input logic xf, input logic xl);
        out_q.push_back('{width: width, x_first: xf, x_last: xl});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives mask for one sampling edge, then returns all inputs low.
    task automatic rise(input logic [N_IN-1:0] mask, input logic clr);
        @(negedge clk);
        in      = mask;
        cnt_clr = clr;
        @(negedge clk);
        in      = '0;
        cnt_clr = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_out",      32'(out),      0);
        check("rst_out_x",    32'(out_x),    0);
        check("rst_viol",     32'(viol),     0);
        check("rst_viol_src", 32'(viol_src), 0);
        check("rst_viol_cnt", 32'(viol_cnt), 0);
    endtask

    initial begin : monitor
        viol_rec_t vr;
        out_rec_t  orec;
        bit        in_run;
        int        width;
        logic      xf, xl;
        in_run = 1'b0;
        width  = 0;
        xf     = 1'b0;
        xl     = 1'b0;
        forever begin
            @(negedge clk);
            if (viol) begin
                if (viol_q.size() == 0) begin
                    check("viol_unexpected", 32'(viol), 0);
                end else begin
                    vr = viol_q.pop_front();
                    check("viol_src", 32'(viol_src), 32'(vr.src));
                    check("viol_cnt", 32'(viol_cnt), 32'(vr.cnt));
                end
            end
            if (out) begin
                if (!in_run) begin
                    in_run = 1'b1;
                    width  = 0;
                    xf     = out_x;
                end
                width++;
                xl = out_x;
            end else if (in_run) begin
                in_run = 1'b0;
                if (out_q.size() == 0) begin
                    check("out_unexpected_width", 32'(width), 0);
                end else begin
                    orec = out_q.pop_front();
                    check("out_width",   32'(width), 32'(orec.width));
                    check("out_x_first", 32'(xf),    32'(orec.x_first));
                    check("out_x_last",  32'(xl),    32'(orec.x_last));
                end
            end
        end
    end

    initial begin : stimulus
        int drain;
        idle(3);
        check_reset_values();
        rst_n = 1'b1;
        idle(3);

        // Single clean rise.
        expect_out(2, 1'b0, 1'b0);
        rise(4'b0001, 1'b0);
        idle(15);

        // Second rise T_SEP-1 cycles later violates.
        expect_out(2, 1'b0, 1'b0);
        rise(4'b0010, 1'b0);
        idle(7);
        expect_viol(4'b0100, 1'b0);
        expect_out(2, 1'b1, 1'b1);
        rise(4'b0100, 1'b0);
        idle(15);

        // Second rise exactly T_SEP cycles later is clean.
        expect_out(2, 1'b0, 1'b0);
        rise(4'b0010, 1'b0);
        idle(8);
        expect_out(2, 1'b0, 1'b0);
        rise(4'b0100, 1'b0);
        idle(15);

        // Simultaneous edges: one tainted pulse.
        expect_viol(4'b1001, 1'b0);
        expect_out(2, 1'b1, 1'b1);
        rise(4'b1001, 1'b0);
        idle(15);
        check("viol_src_held", 32'(viol_src), 32'(4'b1001));

        // Two events two cycles apart: output restarts without a gap and turns invalid.
        expect_out(4, 1'b0, 1'b1);
        rise(4'b0001, 1'b0);
        expect_viol(4'b0001, 1'b0);
        rise(4'b0001, 1'b0);
        idle(15);

        // Input held high through reset release gives no event.
        @(negedge clk);
        rst_n   = 1'b0;
        in      = 4'b0100;
        exp_cnt = 0;
        idle(2);
        check_reset_values();
        rst_n = 1'b1;
        idle(5);
        in = '0;
        idle(15);
        check("hold_viol_cnt", 32'(viol_cnt), 0);
        check("hold_viol_src", 32'(viol_src), 0);

        // Reset one cycle after an accepted edge drops the pulse.
        rise(4'b0001, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_cnt = 0;
        idle(2);
        rst_n = 1'b1;
        idle(15);

        // 17 collisions saturate the 4-bit counter; clear with a violation leaves 1.
        expect_out(36, 1'b1, 1'b1);
        for (int k = 0; k < 17; k++) begin
            expect_viol(4'b0011, 1'b0);
            rise(4'b0011, 1'b0);
        end
        expect_viol(4'b0011, 1'b1);
        rise(4'b0011, 1'b1);
        idle(15);
        check("cnt_after_clr", 32'(viol_cnt), 1);

`ifdef CONF_TSTAMP_EN
        @(negedge clk);
        rst_n   = 1'b0;
        exp_cnt = 0;
        idle(2);
        rst_n = 1'b1;
        while (cyc != 100) @(negedge clk);
        expect_out(2, 1'b0, 1'b0);
        in = 4'b0001;
        @(negedge clk);
        in = '0;
        while (cyc != 105) @(negedge clk);
        expect_viol(4'b0010, 1'b0);
        expect_out(2, 1'b1, 1'b1);
        in = 4'b0010;
        @(negedge clk);
        in = '0;
        idle(10);
        check("viol_prev_time", viol_prev_time, 100);
        check("viol_time",      viol_time,      105);
        check("last_evt_time",  last_evt_time,  105);
`endif

        drain = 0;
        while ((viol_q.size() != 0 || out_q.size() != 0) && drain < 100) begin
            @(negedge clk);
            drain++;
        end
        check("viol_q_drained", 32'(viol_q.size()), 0);
        check("out_q_drained",  32'(out_q.size()),  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
